hazard_fwd_ctrl: RTL and testbench

Parametrised hazard detection and forwarding controller for the ID stage of the pipelined MIPS core. It generalises forwarding to NUM_FWD producer stages and any register-address width, and adds multi-cycle load-use stalls and a branch-flush sequencer. Forwarding selects are combinational. Stall, flush and hazard status come from a small registered FSM. It drives the ID-stage operand muxes, the PC / IF-ID enables and the ID/EX bubble insert.

---
 rtl/hazard_fwd_ctrl_if.sv | 47 ++++
 rtl/hazard_fwd_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_fwd_ctrl_if.sv
// ID-stage hazard/forwarding bus between the decode stage (master) and hazard_fwd_ctrl (slave).
// HFU_PERF_CNT_EN adds the stall/flush cycle counter outputs.
interface hazard_fwd_ctrl_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 3,
    parameter int SEL_W   = $clog2(NUM_FWD + 1)
);
    logic [REG_AW-1:0]         id_rs;
    logic [REG_AW-1:0]         id_rt;
    logic                      id_uses_rs;
    logic                      id_uses_rt;
    logic [NUM_FWD*REG_AW-1:0] fwd_dest;
    logic [NUM_FWD-1:0]        fwd_rf_en;
    logic [NUM_FWD-1:0]        fwd_load;
    logic                      branch_taken;
    logic [SEL_W-1:0]          pa_sel;
    logic [SEL_W-1:0]          pb_sel;
    logic                      pc_enable;
    logic                      load_enable;
    logic                      nop_signal;
    logic                      flush;
    logic [1:0]                hazard_type;
`ifdef HFU_PERF_CNT_EN
    logic [15:0]               stall_cycles;
    logic [15:0]               flush_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, fwd_dest, fwd_rf_en, fwd_load, branch_taken,
        input  pa_sel, pb_sel, pc_enable, load_enable, nop_signal, flush, hazard_type,
               stall_cycles, flush_cycles
    );
    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, fwd_dest, fwd_rf_en, fwd_load, branch_taken,
        output pa_sel, pb_sel, pc_enable, load_enable, nop_signal, flush, hazard_type,
               stall_cycles, flush_cycles
    );
`else
    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, fwd_dest, fwd_rf_en, fwd_load, branch_taken,
        input  pa_sel, pb_sel, pc_enable, load_enable, nop_signal, flush, hazard_type
    );
    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, fwd_dest, fwd_rf_en, fwd_load, branch_taken,
        output pa_sel, pb_sel, pc_enable, load_enable, nop_signal, flush, hazard_type
    );
`endif
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// ID-stage hazard detection, operand forwarding and branch-flush sequencing.
// Define HFU_PERF_CNT_EN to add saturating stall/flush cycle counters.
module hazard_fwd_ctrl #(
    parameter int REG_AW         = 5,
    parameter int NUM_FWD        = 3,
    parameter int LOAD_READY_IDX = 1,
    parameter int FLUSH_CYCLES   = 1,
    parameter int SEL_W          = $clog2(NUM_FWD + 1)
) (
    input logic              clk,
    input logic              rst_n,
    hazard_fwd_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [1:0] r_hazard;

    logic [NUM_FWD-1:0] w_rs_hit, w_rt_hit, w_conf;
    logic               w_rs_ok, w_rt_ok;
    logic [SEL_W-1:0]   w_pa, w_pb;
    logic               w_conflict;
    logic [3:0]         w_need;
    logic               w_pc_en, w_ld_en, w_nop, w_flush;
    state_t             w_nxt_state;
    logic [3:0]         w_nxt_cnt;

    assign w_rs_ok = bus.id_uses_rs && (bus.id_rs != '0);
    assign w_rt_ok = bus.id_uses_rt && (bus.id_rt != '0);

    for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_src
        logic [REG_AW-1:0] w_dest;
        assign w_dest       = bus.fwd_dest[gi*REG_AW +: REG_AW];
        assign w_rs_hit[gi] = w_rs_ok && bus.fwd_rf_en[gi] && (w_dest == bus.id_rs);
        assign w_rt_hit[gi] = w_rt_ok && bus.fwd_rf_en[gi] && (w_dest == bus.id_rt);
        // Only stages before LOAD_READY_IDX lack the loaded value.
        if (gi < LOAD_READY_IDX) begin : g_early
            assign w_conf[gi] = bus.fwd_load[gi] && (w_rs_hit[gi] || w_rt_hit[gi]);
        end else begin : g_late
            assign w_conf[gi] = 1'b0;
        end
    end

    // Scan from the farthest stage down so the nearest match wins.
    always_comb begin
        w_pa       = '0;
        w_pb       = '0;
        w_conflict = 1'b0;
        w_need     = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (w_rs_hit[i]) w_pa = SEL_W'(i + 1);
            if (w_rt_hit[i]) w_pb = SEL_W'(i + 1);
            if (w_conf[i]) begin
                w_conflict = 1'b1;
                w_need     = 4'(LOAD_READY_IDX - i);
            end
        end
    end

    always_comb begin
        w_pc_en     = 1'b1;
        w_ld_en     = 1'b1;
        w_nop       = 1'b0;
        w_flush     = 1'b0;
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        if (r_state == FLUSH) begin
            w_flush = 1'b1;
            w_nop   = 1'b1;
            if (bus.branch_taken && FLUSH_CYCLES > 1) begin
                w_nxt_cnt = FLUSH_RELOAD;
            end else if (bus.branch_taken || r_cnt <= 4'd1) begin
                w_nxt_state = RUN;
                w_nxt_cnt   = '0;
            end else begin
                w_nxt_cnt = r_cnt - 4'd1;
            end
        end else if (bus.branch_taken) begin
            // A taken branch also cancels any stall in progress.
            w_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_nxt_state = FLUSH;
                w_nxt_cnt   = FLUSH_RELOAD;
            end else begin
                w_nxt_state = RUN;
                w_nxt_cnt   = '0;
            end
        end else if (r_state == STALL) begin
            w_pc_en = 1'b0;
            w_ld_en = 1'b0;
            w_nop   = 1'b1;
            if (r_cnt <= 4'd1) begin
                w_nxt_state = RUN;
                w_nxt_cnt   = '0;
            end else begin
                w_nxt_cnt = r_cnt - 4'd1;
            end
        end else if (w_conflict) begin
            w_pc_en = 1'b0;
            w_ld_en = 1'b0;
            w_nop   = 1'b1;
            if (w_need > 4'd1) begin
                w_nxt_state = STALL;
                w_nxt_cnt   = w_need - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_cnt    <= '0;
            r_hazard <= 2'b00;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            if (w_flush)                    r_hazard <= 2'b11;
            else if (w_nop)                 r_hazard <= 2'b01;
            else if ((w_pa | w_pb) != '0)   r_hazard <= 2'b10;
            else                            r_hazard <= 2'b00;
        end
    end

    // Outputs are held at their idle values while reset is asserted.
    assign bus.pa_sel      = rst_n ? w_pa : '0;
    assign bus.pb_sel      = rst_n ? w_pb : '0;
    assign bus.pc_enable   = w_pc_en | ~rst_n;
    assign bus.load_enable = w_ld_en | ~rst_n;
    assign bus.nop_signal  = w_nop & rst_n;
    assign bus.flush       = w_flush & rst_n;
    assign bus.hazard_type = r_hazard;

`ifdef HFU_PERF_CNT_EN
    logic [15:0] r_stall_cnt, r_flush_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_nop && !w_flush && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_flush && r_flush_cnt != 16'hFFFF)           r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end
    assign bus.stall_cycles = r_stall_cnt;
    assign bus.flush_cycles = r_flush_cnt;
`endif
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Randomized + directed bench: two controllers (default and LOAD_READY_IDX=3/FLUSH_CYCLES=3) vs a counter-based model.
module tb_hazard_fwd_ctrl;
    localparam int REG_AW  = 5;
    localparam int NUM_FWD = 3;
    localparam int SEL_W   = $clog2(NUM_FWD + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [REG_AW-1:0]         s_rs, s_rt;
    logic                      s_urs, s_urt, s_br;
    logic [NUM_FWD*REG_AW-1:0] s_dest;
    logic [NUM_FWD-1:0]        s_en, s_ld;

    hazard_fwd_ctrl_if #(.REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) bus0 ();
    hazard_fwd_ctrl_if #(.REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) bus1 ();

    assign bus0.id_rs = s_rs;   assign bus1.id_rs = s_rs;
    assign bus0.id_rt = s_rt;   assign bus1.id_rt = s_rt;
    assign bus0.id_uses_rs = s_urs;   assign bus1.id_uses_rs = s_urs;
    assign bus0.id_uses_rt = s_urt;   assign bus1.id_uses_rt = s_urt;
    assign bus0.fwd_dest = s_dest;    assign bus1.fwd_dest = s_dest;
    assign bus0.fwd_rf_en = s_en;     assign bus1.fwd_rf_en = s_en;
    assign bus0.fwd_load = s_ld;      assign bus1.fwd_load = s_ld;
    assign bus0.branch_taken = s_br;  assign bus1.branch_taken = s_br;

    hazard_fwd_ctrl #(.REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .LOAD_READY_IDX(1), .FLUSH_CYCLES(1))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    hazard_fwd_ctrl #(.REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .LOAD_READY_IDX(3), .FLUSH_CYCLES(3))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    logic [SEL_W-1:0] o_pa[2], o_pb[2];
    logic             o_pc[2], o_le[2], o_nop[2], o_fl[2];
    logic [1:0]       o_ht[2];
    assign o_pa[0] = bus0.pa_sel;       assign o_pa[1] = bus1.pa_sel;
    assign o_pb[0] = bus0.pb_sel;       assign o_pb[1] = bus1.pb_sel;
    assign o_pc[0] = bus0.pc_enable;    assign o_pc[1] = bus1.pc_enable;
    assign o_le[0] = bus0.load_enable;  assign o_le[1] = bus1.load_enable;
    assign o_nop[0] = bus0.nop_signal;  assign o_nop[1] = bus1.nop_signal;
    assign o_fl[0] = bus0.flush;        assign o_fl[1] = bus1.flush;
    assign o_ht[0] = bus0.hazard_type;  assign o_ht[1] = bus1.hazard_type;
`ifdef HFU_PERF_CNT_EN
    logic [15:0] o_sc[2], o_fc[2];
    assign o_sc[0] = bus0.stall_cycles;  assign o_sc[1] = bus1.stall_cycles;
    assign o_fc[0] = bus0.flush_cycles;  assign o_fc[1] = bus1.flush_cycles;
`endif

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model: remaining stall/flush cycles per configuration, not a state encoding.
    function automatic int lri(input int k); return (k == 0) ? 1 : 3; endfunction
    function automatic int fcy(input int k); return (k == 0) ? 1 : 3; endfunction

    int m_stall[2], m_flush[2], m_ht[2], m_sc[2], m_fc[2];
    int e_pa, e_pb;
    int e_pc[2], e_nop[2], e_fl[2], nx_stall[2], nx_flush[2], nx_ht[2];

    function automatic bit hit(input int j, input logic [REG_AW-1:0] a, input logic use_it);
        return use_it && (a != 0) && s_en[j] && (s_dest[j*REG_AW +: REG_AW] == a);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_stall[k] = 0; m_flush[k] = 0; m_ht[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end
    endtask

    task automatic model_comb();
        e_pa = 0; e_pb = 0;
        for (int j = 0; j < NUM_FWD; j++) begin
            if (e_pa == 0 && hit(j, s_rs, s_urs)) e_pa = j + 1;
            if (e_pb == 0 && hit(j, s_rt, s_urt)) e_pb = j + 1;
        end
        for (int k = 0; k < 2; k++) begin
            int cj;
            cj = -1;
            for (int j = 0; j < lri(k) && j < NUM_FWD; j++)
                if (cj < 0 && s_ld[j] && (hit(j, s_rs, s_urs) || hit(j, s_rt, s_urt))) cj = j;
            e_pc[k] = 1; e_nop[k] = 0; e_fl[k] = 0;
            nx_stall[k] = m_stall[k]; nx_flush[k] = m_flush[k];
            if (m_flush[k] > 0) begin
                e_fl[k] = 1; e_nop[k] = 1;
                nx_flush[k] = s_br ? fcy(k) - 1 : m_flush[k] - 1;
            end else if (s_br) begin
                e_fl[k] = 1; nx_flush[k] = fcy(k) - 1; nx_stall[k] = 0;
            end else if (m_stall[k] > 0) begin
                e_pc[k] = 0; e_nop[k] = 1; nx_stall[k] = m_stall[k] - 1;
            end else if (cj >= 0) begin
                e_pc[k] = 0; e_nop[k] = 1; nx_stall[k] = lri(k) - cj - 1;
            end
            nx_ht[k] = e_fl[k] ? 3 : e_nop[k] ? 1 : (e_pa != 0 || e_pb != 0) ? 2 : 0;
        end
    endtask

    // One cycle: inputs already driven just after a rising edge.
    task automatic step();
        #2;
        model_comb();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("pa_sel%0d", k), 32'(o_pa[k]), 32'(e_pa));
            chk($sformatf("pb_sel%0d", k), 32'(o_pb[k]), 32'(e_pb));
            chk($sformatf("pc_en%0d", k), 32'(o_pc[k]), 32'(e_pc[k]));
            chk($sformatf("ld_en%0d", k), 32'(o_le[k]), 32'(e_pc[k]));
            chk($sformatf("nop%0d", k), 32'(o_nop[k]), 32'(e_nop[k]));
            chk($sformatf("flush%0d", k), 32'(o_fl[k]), 32'(e_fl[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            m_stall[k] = nx_stall[k]; m_flush[k] = nx_flush[k]; m_ht[k] = nx_ht[k];
            if (e_nop[k] && !e_fl[k] && m_sc[k] < 65535) m_sc[k]++;
            if (e_fl[k] && m_fc[k] < 65535) m_fc[k]++;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("htype%0d", k), 32'(o_ht[k]), 32'(m_ht[k]));
`ifdef HFU_PERF_CNT_EN
            chk($sformatf("stall_cyc%0d", k), 32'(o_sc[k]), 32'(m_sc[k]));
            chk($sformatf("flush_cyc%0d", k), 32'(o_fc[k]), 32'(m_fc[k]));
`endif
        end
    endtask

    task automatic clear_in();
        s_rs = '0; s_rt = '0; s_urs = 1'b0; s_urt = 1'b0; s_br = 1'b0;
        s_dest = '0; s_en = '0; s_ld = '0;
    endtask

    task automatic set_src(input int j, input int dest, input bit en, input bit ld);
        s_dest[j*REG_AW +: REG_AW] = REG_AW'(dest);
        s_en[j] = en;
        s_ld[j] = ld;
    endtask

    initial begin
        int nstall;
        clear_in();
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_pc%0d", k), 32'(o_pc[k]), 32'd1);
            chk($sformatf("rst_nop%0d", k), 32'(o_nop[k]), 32'd0);
            chk($sformatf("rst_ht%0d", k), 32'(o_ht[k]), 32'd0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Forwarding priority: nearest source wins, r0 never forwarded.
        s_rs = 5; s_urs = 1'b1; set_src(0, 5, 1, 0); set_src(2, 5, 1, 0);
        #1 chk("fwd_pri_ex", 32'(o_pa[0]), 32'd1);
        step();
        s_en[0] = 1'b0;
        #1 chk("fwd_pri_wb", 32'(o_pa[0]), 32'd3);
        step();
        s_rs = 0; set_src(0, 0, 1, 0); set_src(2, 0, 1, 0);
        #1 chk("fwd_r0", 32'(o_pa[0]), 32'd0);
        step();

        // Default load-use: one bubble, then status 01.
        clear_in();
        s_rt = 7; s_urt = 1'b1; set_src(0, 7, 1, 1);
        #1 chk("lu_pc", 32'(o_pc[0]), 32'd0);
        chk("lu_nop", 32'(o_nop[0]), 32'd1);
        step();
        chk("lu_ht", 32'(o_ht[0]), 32'd1);
        clear_in();
        step();
        chk("lu_pc_after", 32'(o_pc[0]), 32'd1);
        step(); step();

        // Reset asserted mid-stall on the deep configuration.
        s_rs = 9; s_urs = 1'b1; set_src(0, 9, 1, 1);
        step();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("arst_pc%0d", k), 32'(o_pc[k]), 32'd1);
            chk($sformatf("arst_nop%0d", k), 32'(o_nop[k]), 32'd0);
            chk($sformatf("arst_ht%0d", k), 32'(o_ht[k]), 32'd0);
            chk($sformatf("arst_pa%0d", k), 32'(o_pa[k]), 32'd0);
        end
        @(posedge clk); #1;
        clear_in();
        model_reset();
        rst_n = 1'b1;

        // Multi-cycle stall: load at index 0 with LOAD_READY_IDX=3.
        nstall = 0;
        s_rs = 9; s_urs = 1'b1; set_src(0, 9, 1, 1);
        #1 if (!o_pc[1]) nstall++;
        step();
        clear_in();
        for (int c = 0; c < 3; c++) begin
            #1 if (!o_pc[1]) nstall++;
            step();
        end
        chk("mstall_len", 32'(nstall), 32'd3);

        // Branch coincident with a load-use: flush wins for FLUSH_CYCLES.
        nstall = 0;
        s_br = 1'b1; s_rs = 9; s_urs = 1'b1; set_src(0, 9, 1, 1);
        #1 if (o_fl[1]) nstall++;
        step();
        chk("flush_ht", 32'(o_ht[1]), 32'd3);
        clear_in();
        for (int c = 0; c < 3; c++) begin
            #1 if (o_fl[1]) nstall++;
            chk("flush_nostall", 32'(o_pc[1]), 32'd1);
            step();
        end
        chk("flush_len", 32'(nstall), 32'd3);
`ifdef HFU_PERF_CNT_EN
        chk("perf_stall", 32'(o_sc[1]), 32'd3);
        chk("perf_flush", 32'(o_fc[1]), 32'd3);
`endif

        // Randomized traffic with a small register space to force matches.
        for (int c = 0; c < 600; c++) begin
            s_rs  = REG_AW'($urandom_range(0, 7));
            s_rt  = REG_AW'($urandom_range(0, 7));
            s_urs = 1'($urandom_range(0, 3) != 0);
            s_urt = 1'($urandom_range(0, 1));
            s_br  = 1'($urandom_range(0, 9) == 0);
            for (int j = 0; j < NUM_FWD; j++)
                set_src(j, $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
